// File: rtl/alu_seq_hs.sv
// Registered ALU with valid/ready handshakes: single-cycle ops finish on the accept edge, and MUL/DIV take WIDTH more edges.
// While a result is waiting for out_ready, no new operands are accepted and the result and flags hold steady.
module alu_seq_hs #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry,
   output logic             zero,
   output logic             ovf,
   output logic             dz
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_DIV  = 4'h3;
   localparam logic [3:0] OP_SHL  = 4'h4;
   localparam logic [3:0] OP_SHR  = 4'h5;
   localparam logic [3:0] OP_ROL  = 4'h6;
   localparam logic [3:0] OP_ROR  = 4'h7;
   localparam logic [3:0] OP_AND  = 4'h8;
   localparam logic [3:0] OP_OR   = 4'h9;
   localparam logic [3:0] OP_XOR  = 4'hA;
   localparam logic [3:0] OP_NOR  = 4'hB;
   localparam logic [3:0] OP_NAND = 4'hC;
   localparam logic [3:0] OP_XNOR = 4'hD;

   localparam int MSB = WIDTH - 1;

   logic [1:0]       state;
   logic             mul_op;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [5:0]       cnt;

   logic             accept;
   logic             start_iter;
   logic [WIDTH:0]   add_s;
   logic [WIDTH:0]   sub_d;
   logic [WIDTH-1:0] sc_res;
   logic [WIDTH-1:0] sc_hi;
   logic             sc_c;
   logic             sc_v;
   logic             sc_dz;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_sh;
   logic [WIDTH-1:0] div_rem;
   logic             div_ge;
   logic [WIDTH-1:0] nxt_hi;
   logic [WIDTH-1:0] nxt_lo;

   assign in_ready   = (state == S_IDLE);
   assign out_valid  = (state == S_DONE);
   assign accept     = in_valid & in_ready;
   assign start_iter = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));

   assign add_s = {1'b0, a} + {1'b0, b};
   assign sub_d = {1'b0, a} - {1'b0, b};

   always_comb begin
      sc_res = '0;
      sc_hi  = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      sc_dz  = 1'b0;
      case (op)
         OP_SUB: begin
            sc_res = sub_d[MSB:0];
            sc_c   = sub_d[WIDTH];
            sc_v   = (a[MSB] != b[MSB]) && (sub_d[MSB] != a[MSB]);
         end
         OP_MUL: sc_res = '0;
         OP_DIV: begin
            sc_res = '1;
            sc_hi  = a;
            sc_dz  = 1'b1;
         end
         OP_SHL:  begin sc_res = {a[MSB-1:0], 1'b0};   sc_c = a[MSB]; end
         OP_SHR:  begin sc_res = {1'b0, a[MSB:1]};     sc_c = a[0];   end
         OP_ROL:  begin sc_res = {a[MSB-1:0], a[MSB]}; sc_c = a[MSB]; end
         OP_ROR:  begin sc_res = {a[0], a[MSB:1]};     sc_c = a[0];   end
         OP_AND:  sc_res = a & b;
         OP_OR:   sc_res = a | b;
         OP_XOR:  sc_res = a ^ b;
         OP_NOR:  sc_res = ~(a | b);
         OP_NAND: sc_res = ~(a & b);
         OP_XNOR: sc_res = ~(a ^ b);
         // ADD, plus the spare encodings E/F
         default: begin
            sc_res = add_s[MSB:0];
            sc_c   = add_s[WIDTH];
            sc_v   = (a[MSB] == b[MSB]) && (add_s[MSB] != a[MSB]);
         end
      endcase
   end

   // hi/lo hold {accumulator, multiplier} for MUL and {remainder, dividend} for DIV
   assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
   assign div_sh  = {hi, lo[MSB]};
   assign div_ge  = (div_sh >= {1'b0, opnd});
   assign div_rem = div_sh[MSB:0] - opnd;

   always_comb begin
      if (mul_op) begin
         nxt_hi = mul_sum[WIDTH:1];
         nxt_lo = {mul_sum[0], lo[MSB:1]};
      end else begin
         nxt_hi = div_ge ? div_rem : div_sh[MSB:0];
         nxt_lo = {lo[MSB-1:0], div_ge};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         mul_op    <= 1'b0;
         opnd      <= '0;
         hi        <= '0;
         lo        <= '0;
         cnt       <= '0;
         result    <= '0;
         result_hi <= '0;
         carry     <= 1'b0;
         zero      <= 1'b0;
         ovf       <= 1'b0;
         dz        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (start_iter) begin
                     state  <= S_BUSY;
                     mul_op <= (op == OP_MUL);
                     opnd   <= (op == OP_MUL) ? a : b;
                     lo     <= (op == OP_MUL) ? b : a;
                     hi     <= '0;
                     cnt    <= '0;
                  end else begin
                     state     <= S_DONE;
                     result    <= sc_res;
                     result_hi <= sc_hi;
                     carry     <= sc_c;
                     zero      <= (sc_res == '0);
                     ovf       <= sc_v;
                     dz        <= sc_dz;
                  end
               end
            end
            S_BUSY: begin
               hi  <= nxt_hi;
               lo  <= nxt_lo;
               cnt <= cnt + 6'd1;
               if (cnt == 6'(WIDTH - 1)) begin
                  state     <= S_DONE;
                  result    <= nxt_lo;
                  result_hi <= nxt_hi;
                  carry     <= 1'b0;
                  zero      <= (nxt_lo == '0);
                  ovf       <= mul_op && (nxt_hi != '0);
                  dz        <= 1'b0;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_hs.sv
// Bench for alu_seq_hs: directed vector table, hand-written sequences for backpressure and reset abort,
// and random operations checked against an arithmetic reference model.
module tb_alu_seq_hs;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [3:0]   op = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic [W-1:0] result_hi;
   logic         carry, zero, ovf, dz;

   int errors = 0;
   int checks = 0;

   alu_seq_hs #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_hi(result_hi),
      .carry(carry), .zero(zero), .ovf(ovf), .dz(dz)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic [3:0]   flg;   // {carry, zero, ovf, dz}
   } vec_t;

   vec_t vecs[23];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the operation definitions.
   function automatic void model(input logic [3:0] o, input longint x, input longint y,
                                 output longint r, output longint h, output logic [3:0] f);
      longint m, half, sx, sy, sr, t;
      logic c, v, d;
      m = longint'(1) << W;
      half = m / 2;
      sx = (x >= half) ? x - m : x;
      sy = (y >= half) ? y - m : y;
      r = 0; h = 0; c = 0; v = 0; d = 0;
      case (o)
         4'h1: begin r = (x - y + m) % m; c = (x < y); sr = sx - sy; v = (sr >= half) || (sr < -half); end
         4'h2: begin t = x * y; r = t % m; h = t / m; v = (h != 0); end
         4'h3: begin
            if (y == 0) begin r = m - 1; h = x; d = 1; end
            else begin r = x / y; h = x % y; end
         end
         4'h4: begin r = (2 * x) % m; c = (x >= half); end
         4'h5: begin r = x / 2; c = ((x % 2) == 1); end
         4'h6: begin r = (2 * x) % m + ((x >= half) ? 1 : 0); c = (x >= half); end
         4'h7: begin r = x / 2 + (x % 2) * half; c = ((x % 2) == 1); end
         4'h8: r = x & y;
         4'h9: r = x | y;
         4'hA: r = x ^ y;
         4'hB: r = (~(x | y)) & (m - 1);
         4'hC: r = (~(x & y)) & (m - 1);
         4'hD: r = (~(x ^ y)) & (m - 1);
         default: begin t = x + y; r = t % m; c = (t >= m); sr = sx + sy; v = (sr >= half) || (sr < -half); end
      endcase
      f = {c, (r == 0), v, d};
   endfunction

   function automatic int exp_lat(input logic [3:0] o, input logic [W-1:0] y);
      return ((o == 4'h2) || ((o == 4'h3) && (y != '0))) ? W + 1 : 1;
   endfunction

   // Issue one op, wait for the result (bounded), optionally stall, then release it.
   task automatic run_op(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input int stall, output logic [W-1:0] r, output logic [W-1:0] rh,
                         output logic [3:0] f, output int lat);
      @(negedge clk);
      in_valid = 1'b1; op = o; a = xa; b = xb;
      @(posedge clk); #1;
      in_valid = 1'b0; a = W'($urandom); b = W'($urandom); op = 4'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 100);
      r = result; rh = result_hi; f = {carry, zero, ovf, dz};
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("hold", {out_valid, in_ready, result, result_hi, carry, zero, ovf, dz},
             {2'b10, r, rh, f});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (stall > 0) chk("release", {out_valid, in_ready}, 2'b01);
   endtask

   initial begin
      logic [W-1:0] r, rh;
      logic [3:0]   f;
      int           lat;
      longint       mr, mh;
      logic [3:0]   mf;
      logic [3:0]   ro;
      logic [W-1:0] ra, rb;
      bit           seen;

      vecs[0]  = '{4'h0, 8'hC8, 8'h64, 8'h2C, 8'h00, 4'b1000};
      vecs[1]  = '{4'h2, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0010};
      vecs[2]  = '{4'h3, 8'h64, 8'h07, 8'h0E, 8'h02, 4'b0000};
      vecs[3]  = '{4'h3, 8'h05, 8'h00, 8'hFF, 8'h05, 4'b0001};
      vecs[4]  = '{4'h1, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0010};
      vecs[5]  = '{4'h6, 8'h81, 8'h00, 8'h03, 8'h00, 4'b1000};
      vecs[6]  = '{4'hE, 8'h03, 8'h04, 8'h07, 8'h00, 4'b0000};
      vecs[7]  = '{4'h1, 8'h01, 8'h02, 8'hFF, 8'h00, 4'b1000};
      vecs[8]  = '{4'h0, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1100};
      vecs[9]  = '{4'h0, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b0010};
      vecs[10] = '{4'h5, 8'h01, 8'h00, 8'h00, 8'h00, 4'b1100};
      vecs[11] = '{4'h7, 8'h01, 8'h00, 8'h80, 8'h00, 4'b1000};
      vecs[12] = '{4'h4, 8'h80, 8'h00, 8'h00, 8'h00, 4'b1100};
      vecs[13] = '{4'h8, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000};
      vecs[14] = '{4'h9, 8'hF0, 8'h0F, 8'hFF, 8'h00, 4'b0000};
      vecs[15] = '{4'hA, 8'hFF, 8'hFF, 8'h00, 8'h00, 4'b0100};
      vecs[16] = '{4'hB, 8'h00, 8'h00, 8'hFF, 8'h00, 4'b0000};
      vecs[17] = '{4'hC, 8'hFF, 8'hFF, 8'h00, 8'h00, 4'b0100};
      vecs[18] = '{4'hD, 8'hA5, 8'h5A, 8'h00, 8'h00, 4'b0100};
      vecs[19] = '{4'h2, 8'h00, 8'h37, 8'h00, 8'h00, 4'b0100};
      vecs[20] = '{4'h2, 8'h10, 8'h10, 8'h00, 8'h01, 4'b0110};
      vecs[21] = '{4'h3, 8'h07, 8'h64, 8'h00, 8'h07, 4'b0100};
      vecs[22] = '{4'hF, 8'h80, 8'h80, 8'h00, 8'h00, 4'b1110};

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_state", {in_ready, out_valid, result, result_hi, carry, zero, ovf, dz},
          {2'b10, {W{1'b0}}, {W{1'b0}}, 4'b0000});
      rst = 1'b0;

      // Directed table; the first two entries also exercise 5 cycles of backpressure
      for (int i = 0; i < 23; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, (i < 2) ? 5 : 0, r, rh, f, lat);
         chk($sformatf("vec%0d_result", i), r, vecs[i].res);
         chk($sformatf("vec%0d_hi", i), rh, vecs[i].hi);
         chk($sformatf("vec%0d_flags", i), f, vecs[i].flg);
         chk($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].op, vecs[i].b));
      end

      // Reset three cycles into a MUL: nothing may be presented afterwards
      @(negedge clk);
      in_valid = 1'b1; op = 4'h2; a = 8'hFF; b = 8'hFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("abort_in_reset", {out_valid, in_ready}, 2'b01);
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < W + 4; k++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      chk("abort_no_stale_result", seen, 0);
      chk("abort_in_ready", in_ready, 1);
      run_op(4'h0, 8'h01, 8'h01, 0, r, rh, f, lat);
      chk("post_abort_add", {r, rh, f}, {8'h02, 8'h00, 4'b0000});

      // Random operations against the reference model
      for (int n = 0; n < 300; n++) begin
         ro = 4'($urandom_range(15, 0));
         ra = W'($urandom);
         rb = ($urandom_range(7, 0) == 0) ? '0 : W'($urandom);
         run_op(ro, ra, rb, int'($urandom_range(2, 0)), r, rh, f, lat);
         model(ro, longint'(ra), longint'(rb), mr, mh, mf);
         chk($sformatf("rnd%0d_op%0h_%0h_%0h_result", n, ro, ra, rb), r, mr);
         chk($sformatf("rnd%0d_op%0h_%0h_%0h_hi", n, ro, ra, rb), rh, mh);
         chk($sformatf("rnd%0d_op%0h_%0h_%0h_flags", n, ro, ra, rb), f, mf);
         chk($sformatf("rnd%0d_op%0h_latency", n, ro), lat, exp_lat(ro, rb));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
